// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: frames three received bytes (A, B, opcode) onto the ALU,
// then returns the ALU result through the UART transmitter. It also detects
// an inter-byte timeout and a receive overrun.
module uart_alu_ctrl #(
    parameter int DBIT          = 8,
    parameter int OP_W          = 6,
    parameter int TIMEOUT_TICKS = 4096,
    parameter int TO_W          = 12
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            TICK,
    input  logic            RX_DONE,
    input  logic [DBIT-1:0] RX_DATA,
    input  logic            TX_DONE,
    input  logic [DBIT-1:0] ALU_RESULT,
    output logic [DBIT-1:0] ALU_A,
    output logic [DBIT-1:0] ALU_B,
    output logic [OP_W-1:0] ALU_OP,
    output logic            TX_START,
    output logic [DBIT-1:0] TX_DATA,
    output logic            BUSY,
    output logic            ERR_VALID,
    output logic [1:0]      ERR_CODE,
    output logic [2:0]      STATE
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [1:0]      ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]      ERR_OVERRUN = 2'b10;

    state_t          state_reg;
    logic [TO_W-1:0] to_cnt_reg;

    assign STATE = state_reg;

    // Frame sequencer. Every output is registered here, so none of them has a combinational path from the inputs.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg  <= WAIT_A;
            to_cnt_reg <= '0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_OP     <= '0;
            TX_START   <= 1'b0;
            TX_DATA    <= '0;
            BUSY       <= 1'b0;
            ERR_VALID  <= 1'b0;
            ERR_CODE   <= 2'b00;
        end else begin
            TX_START  <= 1'b0;
            ERR_VALID <= 1'b0;
            case (state_reg)
                WAIT_A: begin
                    to_cnt_reg <= '0;
                    if (RX_DONE) begin
                        ALU_A     <= RX_DATA;
                        state_reg <= WAIT_B;
                    end
                end
                WAIT_B, WAIT_OP: begin
                    // A byte arriving together with the expiring tick is still accepted.
                    if (RX_DONE) begin
                        to_cnt_reg <= '0;
                        if (state_reg == WAIT_B) begin
                            ALU_B     <= RX_DATA;
                            state_reg <= WAIT_OP;
                        end else begin
                            ALU_OP    <= RX_DATA[OP_W-1:0];
                            BUSY      <= 1'b1;
                            state_reg <= EXEC;
                        end
                    end else if (TICK) begin
                        if (to_cnt_reg == TO_LAST) begin
                            to_cnt_reg <= '0;
                            ERR_VALID  <= 1'b1;
                            ERR_CODE   <= ERR_TIMEOUT;
                            state_reg  <= WAIT_A;
                        end else begin
                            to_cnt_reg <= to_cnt_reg + 1'b1;
                        end
                    end
                end
                EXEC: begin
                    TX_DATA   <= ALU_RESULT;
                    TX_START  <= 1'b1;
                    state_reg <= SEND;
                end
                SEND: begin
                    state_reg <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (TX_DONE) begin
                        BUSY      <= 1'b0;
                        state_reg <= WAIT_A;
                    end
                end
                default: begin
                    BUSY      <= 1'b0;
                    state_reg <= WAIT_A;
                end
            endcase
            // While a result is being produced or sent, a received byte is dropped and flagged.
            if (RX_DONE && (state_reg == EXEC || state_reg == SEND || state_reg == WAIT_TX)) begin
                ERR_VALID <= 1'b1;
                ERR_CODE  <= ERR_OVERRUN;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed testbench for uart_alu_ctrl. A small behavioural ALU supplies ALU_RESULT.
module tb_uart_alu_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       TICK;
    logic       RX_DONE;
    logic [7:0] RX_DATA;
    logic       TX_DONE;
    logic [7:0] ALU_RESULT;
    logic [7:0] ALU_A;
    logic [7:0] ALU_B;
    logic [5:0] ALU_OP;
    logic       TX_START;
    logic [7:0] TX_DATA;
    logic       BUSY;
    logic       ERR_VALID;
    logic [1:0] ERR_CODE;
    logic [2:0] STATE;

    int vectors = 0;
    int miscompares = 0;

    uart_alu_ctrl dut (
        .CLK(CLK), .RESET(RESET), .TICK(TICK), .RX_DONE(RX_DONE), .RX_DATA(RX_DATA),
        .TX_DONE(TX_DONE), .ALU_RESULT(ALU_RESULT), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_OP(ALU_OP), .TX_START(TX_START), .TX_DATA(TX_DATA), .BUSY(BUSY),
        .ERR_VALID(ERR_VALID), .ERR_CODE(ERR_CODE), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Stand-in ALU: 0x20 add, 0x22 subtract, anything else xor.
    always_comb begin
        ALU_RESULT = ALU_A ^ ALU_B;
        if (ALU_OP == 6'h20) ALU_RESULT = ALU_A + ALU_B;
        else if (ALU_OP == 6'h22) ALU_RESULT = ALU_A - ALU_B;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA = b;
        RX_DONE = 1'b1;
        step();
        RX_DONE = 1'b0;
        RX_DATA = 8'h00;
    endtask

    task automatic ticks(input int n);
        TICK = 1'b1;
        for (int i = 0; i < n; i++) step();
        TICK = 1'b0;
    endtask

    // Full frame from WAIT_A back to WAIT_A, with the expected transmitted byte.
    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] exp);
        send_byte(a);
        chk({tag, "_a"}, ALU_A, a);
        chk({tag, "_st_b"}, STATE, 1);
        send_byte(b);
        chk({tag, "_b"}, ALU_B, b);
        send_byte(op);
        chk({tag, "_st_exec"}, STATE, 3);
        chk({tag, "_op"}, ALU_OP, op & 8'h3f);
        chk({tag, "_busy"}, BUSY, 1);
        chk({tag, "_nostart"}, TX_START, 0);
        step();
        chk({tag, "_start"}, TX_START, 1);
        chk({tag, "_txd"}, TX_DATA, exp);
        step();
        chk({tag, "_start_end"}, TX_START, 0);
        chk({tag, "_st_wtx"}, STATE, 5);
        TX_DONE = 1'b1;
        step();
        TX_DONE = 1'b0;
        chk({tag, "_st_done"}, STATE, 0);
        chk({tag, "_idle"}, BUSY, 0);
        chk({tag, "_txd_hold"}, TX_DATA, exp);
        $display("frame %s a=%02h b=%02h op=%02h tx=%02h", tag, a, b, op, TX_DATA);
    endtask

    initial begin
        RESET = 1'b0; TICK = 1'b0; RX_DONE = 1'b0; RX_DATA = 8'h00; TX_DONE = 1'b0;
        step();
        step();
        chk("rst_state", STATE, 0);
        chk("rst_a", ALU_A, 0);
        chk("rst_txd", TX_DATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_err", {ERR_VALID, ERR_CODE}, 0);
        RESET = 1'b1;
        step();

        // 1: ADD 5+3
        frame("add", 8'h05, 8'h03, 8'h20, 8'h08);

        // 2: inter-byte timeout after byte A
        send_byte(8'h11);
        ticks(4095);
        chk("to_pre_state", STATE, 1);
        chk("to_pre_err", ERR_VALID, 0);
        ticks(1);
        chk("to_state", STATE, 0);
        chk("to_valid", ERR_VALID, 1);
        chk("to_code", ERR_CODE, 1);
        step();
        chk("to_pulse", ERR_VALID, 0);
        chk("to_code_hold", ERR_CODE, 1);
        $display("timeout err_code=%0d", ERR_CODE);
        frame("after_to", 8'h07, 8'h02, 8'h20, 8'h09);

        // 3: opcode byte coincides with the expiring tick
        send_byte(8'h01);
        send_byte(8'h02);
        ticks(4095);
        chk("race_pre_state", STATE, 2);
        RX_DATA = 8'h20; RX_DONE = 1'b1; TICK = 1'b1;
        step();
        RX_DONE = 1'b0; TICK = 1'b0; RX_DATA = 8'h00;
        chk("race_state", STATE, 3);
        chk("race_err", ERR_VALID, 0);
        chk("race_op", ALU_OP, 6'h20);
        $display("race state=%0d op=%02h", STATE, ALU_OP);
        step();
        chk("race_txd", TX_DATA, 8'h03);
        step();
        chk("race_wtx", STATE, 5);

        // 4: overrun during WAIT_TX
        send_byte(8'hAA);
        chk("ovr_valid", ERR_VALID, 1);
        chk("ovr_code", ERR_CODE, 2);
        chk("ovr_state", STATE, 5);
        chk("ovr_txd", TX_DATA, 8'h03);
        step();
        chk("ovr_pulse", ERR_VALID, 0);
        TX_DONE = 1'b1;
        step();
        TX_DONE = 1'b0;
        chk("ovr_back", STATE, 0);
        chk("ovr_a_kept", ALU_A, 8'h01);
        $display("overrun err_code=%0d a=%02h", ERR_CODE, ALU_A);
        frame("after_ovr", 8'h04, 8'h06, 8'h20, 8'h0A);

        // 5: reset in the middle of a frame
        send_byte(8'h09);
        send_byte(8'h0A);
        chk("mid_state", STATE, 2);
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        chk("mrst_state", STATE, 0);
        chk("mrst_a", ALU_A, 0);
        chk("mrst_b", ALU_B, 0);
        chk("mrst_txd", TX_DATA, 0);
        chk("mrst_err", ERR_CODE, 0);
        $display("mid-frame reset state=%0d", STATE);
        frame("after_rst", 8'h33, 8'h11, 8'h20, 8'h44);

        // 6: opcode upper bits ignored, back-to-back frames
        frame("sub", 8'h10, 8'h03, 8'hE2, 8'h0D);
        frame("wrap", 8'hFF, 8'h01, 8'h20, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
